// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory stage: stage payloads, FSM states and access-size codes.
package pipeline_pkg;

  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        w_rd;
    logic        bubble;
    logic        mem_r;
    logic        mem_w;
    logic [1:0]  mem_size;
    logic        mem_sext;
    logic [31:0] store_data;
  } ex_out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        w_rd;
    logic        bubble;
    logic        fault;
  } mem_out_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Misaligned half/word or the reserved size code: such ops never reach the bus.
  function automatic logic mem_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SZ_B: mem_bad = 1'b0;
      MEM_SZ_H: mem_bad = lo[0];
      MEM_SZ_W: mem_bad = (lo != 2'b00);
      default:  mem_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment: load lane extract with sign/zero extension, store lane
// replication and byte enables.
module mem_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      MEM_SZ_B: o_load_data = {{24{i_sext & w_byte[7]}}, w_byte};
      MEM_SZ_H: o_load_data = {{16{i_sext & w_half[15]}}, w_half};
      default:  o_load_data = i_rdata;
    endcase

    case (i_size)
      MEM_SZ_B: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_be    = 4'b0001 << i_addr_lo;
      end
      MEM_SZ_H: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_be    = 4'b0011 << i_addr_lo;
      end
      default: begin
        o_wdata = i_store_data;
        o_be    = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: latches the execute result, performs at most one bus access
// per instruction, and presents the aligned result to writeback.
module stage_mem
  import pipeline_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_out_t     EX,
  output mem_out_t    out,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output mem_state_t  o_dbg_state
);

  // Bus handshake: dmem_req rises with addr/we/wdata/be and they all hold until the cycle in
  // which dmem_ack=1 is seen (or the wait is abandoned); ack outside a request is ignored.

  localparam int              CNT_W  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(BUS_TIMEOUT);

  mem_state_t       r_state;
  ex_out_t          r_ex;
  logic             r_bubble;
  logic             r_fault;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ex_go;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cap_mem;
  logic             w_cap_load;
  logic             w_fault;
  logic             w_out_bubble;
  logic [31:0]      w_load_data;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;

  assign w_ex_go   = !EX.bubble && (EX.mem_r || EX.mem_w) && !mem_bad(EX.mem_size, EX.res[1:0]);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ex     <= '0;
      r_bubble <= 1'b1;
      r_fault  <= 1'b0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        REQ: begin
          if (dmem_ack) begin
            r_rdata <= dmem_rdata;
            r_fault <= 1'b0;
            r_state <= RESP;
          end else if (w_cnt_inc == CNT_TO) begin
            r_fault <= 1'b1;
            r_state <= RESP;
          end
          r_cnt <= w_cnt_inc;
        end
        default: begin
          // IDLE and RESP do not stall, so the next instruction is captured here.
          r_ex     <= EX;
          r_bubble <= EX.bubble;
          r_fault  <= 1'b0;
          r_cnt    <= '0;
          r_state  <= w_ex_go ? REQ : IDLE;
        end
      endcase
    end
  end

  mem_align u_align (
    .i_size       (r_ex.mem_size),
    .i_sext       (r_ex.mem_sext),
    .i_addr_lo    (r_ex.res[1:0]),
    .i_rdata      (r_rdata),
    .i_store_data (r_ex.store_data),
    .o_load_data  (w_load_data),
    .o_wdata      (w_wdata),
    .o_be         (w_be)
  );

  assign w_cap_mem  = r_ex.mem_r || r_ex.mem_w;
  assign w_cap_load = r_ex.mem_r && !r_ex.mem_w;

  always_comb begin
    w_fault = 1'b0;
    if (r_state == RESP)
      w_fault = r_fault;
    else if (r_state == IDLE)
      w_fault = !r_bubble && w_cap_mem && mem_bad(r_ex.mem_size, r_ex.res[1:0]);
  end

  assign w_out_bubble = r_bubble || (r_state == REQ);

  always_comb begin
    out        = '0;
    out.pc     = r_ex.pc;
    out.rd     = r_ex.rd;
    out.bubble = w_out_bubble;
    out.fault  = w_fault;
    out.w_rd   = r_ex.w_rd && !w_out_bubble && !w_fault && !r_ex.mem_w;
    out.res    = (r_state == RESP && w_cap_load && !r_fault) ? w_load_data : r_ex.res;
  end

  assign stall       = (r_state == REQ);
  assign dmem_req    = (r_state == REQ);
  assign dmem_we     = r_ex.mem_w;
  assign dmem_addr   = {r_ex.res[31:2], 2'b00};
  assign dmem_wdata  = w_wdata;
  assign dmem_be     = r_ex.mem_w ? w_be : 4'hF;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: vector table of single instructions plus reset-abort sequence.
module tb_stage_mem;
  import pipeline_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ex_out_t     ex_in;
  mem_out_t    out;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  mem_state_t  dbg_state;

  stage_mem #(.BUS_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .EX          (ex_in),
    .out         (out),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    ex_out_t     ex;
    logic [31:0] rdata;
    int          ack_after;  // 0 = never ack
    int          exp_stall;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_res;
    logic        exp_w_rd;
    logic        exp_fault;
    logic        exp_bubble;
  } vec_t;

  localparam int NV = 17;
  vec_t        vecs[NV];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic ex_out_t mk_ex(input logic [31:0] res, input logic [4:0] rd,
                                    input logic w_rd, input logic bubble, input logic mem_r,
                                    input logic mem_w, input logic [1:0] size, input logic sext,
                                    input logic [31:0] sd);
    ex_out_t e;
    e.pc = 32'h0000_4000 + res; e.res = res; e.rd = rd; e.w_rd = w_rd; e.bubble = bubble;
    e.mem_r = mem_r; e.mem_w = mem_w; e.mem_size = size; e.mem_sext = sext;
    e.store_data = sd;
    return e;
  endfunction

  task automatic set_vec(input int i, input ex_out_t e, input logic [31:0] rdata,
                         input int ack_after, input int exp_stall, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] res, input logic w_rd, input logic fault,
                         input logic bubble);
    vecs[i].ex = e; vecs[i].rdata = rdata; vecs[i].ack_after = ack_after;
    vecs[i].exp_stall = exp_stall; vecs[i].exp_we = we; vecs[i].exp_be = be;
    vecs[i].exp_wdata = wdata; vecs[i].exp_res = res; vecs[i].exp_w_rd = w_rd;
    vecs[i].exp_fault = fault; vecs[i].exp_bubble = bubble;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Driver: present one instruction, service the bus, then check the writeback output.
  task automatic run_vec(input int i);
    vec_t v;
    int   n_stall;
    v = vecs[i];
    ex_in = v.ex;
    exp_q.push_back(v.exp_res);
    step();
    if (v.exp_stall > 0) begin
      check($sformatf("v%0d_req", i), 32'(dmem_req), 32'd1);
      check($sformatf("v%0d_stall", i), 32'(stall), 32'd1);
      check($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v.exp_we));
      check($sformatf("v%0d_addr", i), dmem_addr, {v.ex.res[31:2], 2'b00});
      check($sformatf("v%0d_be", i), 32'(dmem_be), 32'(v.exp_be));
      if (v.exp_we) check($sformatf("v%0d_wdata", i), dmem_wdata, v.exp_wdata);
    end
    n_stall = 0;
    while (dmem_req && n_stall < 40) begin
      n_stall++;
      if (v.ack_after != 0 && n_stall == v.ack_after) begin
        dmem_ack   = 1'b1;
        dmem_rdata = v.rdata;
      end
      step();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5555_AAAA;
    end
    check($sformatf("v%0d_stall_cycles", i), 32'(n_stall), 32'(v.exp_stall));
    check($sformatf("v%0d_stall_low", i), 32'(stall), 32'd0);
    check($sformatf("v%0d_bubble", i), 32'(out.bubble), 32'(v.exp_bubble));
    check($sformatf("v%0d_res", i), out.res, exp_q.pop_front());
    check($sformatf("v%0d_w_rd", i), 32'(out.w_rd), 32'(v.exp_w_rd));
    check($sformatf("v%0d_fault", i), 32'(out.fault), 32'(v.exp_fault));
    check($sformatf("v%0d_pc", i), out.pc, v.ex.pc);
  endtask

  initial begin
    ex_in      = mk_ex(32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MEM_SZ_W, 1'b0, 32'h0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;

    // ALU pass-through
    set_vec(0, mk_ex(32'h1234, 5'd5, 1, 0, 0, 0, MEM_SZ_W, 0, 32'h0), 32'h0, 0, 0,
            0, 4'hF, 32'h0, 32'h1234, 1, 0, 0);
    // Loads
    set_vec(1, mk_ex(32'h103, 5'd6, 1, 0, 1, 0, MEM_SZ_B, 1, 32'h0), 32'h80FF_0011, 3, 3,
            0, 4'hF, 32'h0, 32'hFFFF_FF80, 1, 0, 0);
    set_vec(2, mk_ex(32'h103, 5'd6, 1, 0, 1, 0, MEM_SZ_B, 0, 32'h0), 32'h80FF_0011, 3, 3,
            0, 4'hF, 32'h0, 32'h0000_0080, 1, 0, 0);
    set_vec(3, mk_ex(32'h102, 5'd7, 1, 0, 1, 0, MEM_SZ_H, 1, 32'h0), 32'h8001_1234, 1, 1,
            0, 4'hF, 32'h0, 32'hFFFF_8001, 1, 0, 0);
    set_vec(4, mk_ex(32'h100, 5'd8, 1, 0, 1, 0, MEM_SZ_H, 0, 32'h0), 32'h8001_F00D, 1, 1,
            0, 4'hF, 32'h0, 32'h0000_F00D, 1, 0, 0);
    set_vec(5, mk_ex(32'h104, 5'd9, 1, 0, 1, 0, MEM_SZ_W, 1, 32'h0), 32'hDEAD_BEEF, 2, 2,
            0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1, 0, 0);
    set_vec(6, mk_ex(32'h101, 5'd10, 1, 0, 1, 0, MEM_SZ_B, 1, 32'h0), 32'h0000_7F00, 1, 1,
            0, 4'hF, 32'h0, 32'h0000_007F, 1, 0, 0);
    // Stores (w_rd set upstream must still be suppressed)
    set_vec(7, mk_ex(32'h201, 5'd11, 1, 0, 0, 1, MEM_SZ_B, 0, 32'h0000_00AB), 32'h0, 1, 1,
            1, 4'b0010, 32'hABAB_ABAB, 32'h201, 0, 0, 0);
    set_vec(8, mk_ex(32'h202, 5'd12, 1, 0, 0, 1, MEM_SZ_H, 0, 32'h1234_5678), 32'h0, 2, 2,
            1, 4'b1100, 32'h5678_5678, 32'h202, 0, 0, 0);
    set_vec(9, mk_ex(32'h204, 5'd13, 0, 0, 0, 1, MEM_SZ_W, 0, 32'hCAFE_F00D), 32'h0, 1, 1,
            1, 4'hF, 32'hCAFE_F00D, 32'h204, 0, 0, 0);
    // Misaligned and reserved size: no bus access, one-cycle fault
    set_vec(10, mk_ex(32'h302, 5'd14, 1, 0, 1, 0, MEM_SZ_W, 0, 32'h0), 32'h0, 0, 0,
            0, 4'hF, 32'h0, 32'h302, 0, 1, 0);
    set_vec(11, mk_ex(32'h103, 5'd15, 1, 0, 1, 0, MEM_SZ_H, 1, 32'h0), 32'h0, 0, 0,
            0, 4'hF, 32'h0, 32'h103, 0, 1, 0);
    set_vec(12, mk_ex(32'h300, 5'd16, 1, 0, 1, 0, 2'b11, 0, 32'h0), 32'h0, 0, 0,
            0, 4'hF, 32'h0, 32'h300, 0, 1, 0);
    // mem_r and mem_w together behave as a store
    set_vec(13, mk_ex(32'h203, 5'd17, 1, 0, 1, 1, MEM_SZ_B, 1, 32'h0000_005A), 32'hFFFF_FFFF,
            1, 1, 1, 4'b1000, 32'h5A5A_5A5A, 32'h203, 0, 0, 0);
    // Bus timeout, then ack arriving on the timeout cycle
    set_vec(14, mk_ex(32'h400, 5'd18, 1, 0, 1, 0, MEM_SZ_W, 0, 32'h0), 32'h0, 0, TO,
            0, 4'hF, 32'h0, 32'h400, 0, 1, 0);
    set_vec(15, mk_ex(32'h404, 5'd19, 1, 0, 1, 0, MEM_SZ_W, 0, 32'h0), 32'h1357_9BDF, TO, TO,
            0, 4'hF, 32'h0, 32'h1357_9BDF, 1, 0, 0);
    // Bubble carrying mem_r never touches the bus
    set_vec(16, mk_ex(32'h500, 5'd20, 1, 1, 1, 0, MEM_SZ_W, 0, 32'h0), 32'h0, 0, 0,
            0, 4'hF, 32'h0, 32'h500, 0, 0, 1);

    // Reset state, with a stray ack that must be ignored
    step(); step();
    rst = 1'b0;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("rst_bubble", 32'(out.bubble), 32'd1);
    check("rst_w_rd", 32'(out.w_rd), 32'd0);
    check("rst_fault", 32'(out.fault), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset during the second REQ cycle, ack arriving the cycle after
    ex_in = mk_ex(32'h600, 5'd21, 1, 0, 1, 0, MEM_SZ_W, 0, 32'h0);
    step();
    check("abort_req1", 32'(dmem_req), 32'd1);
    step();
    check("abort_req2", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    ex_in      = mk_ex(32'h0, 5'd0, 0, 1, 0, 0, MEM_SZ_W, 0, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_2222;
    check("abort_req_drop", 32'(dmem_req), 32'd0);
    check("abort_bubble", 32'(out.bubble), 32'd1);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    step();
    dmem_ack = 1'b0;
    check("abort_ack_ignored_req", 32'(dmem_req), 32'd0);
    check("abort_ack_ignored_state", 32'(dbg_state), 32'(IDLE));
    check("abort_no_wb", 32'(out.w_rd), 32'd0);
    check("abort_out_bubble", 32'(out.bubble), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
